// File: rtl/ber_pkg.sv
// Shared types and constants for the BER checker: FSM state encoding,
// search-window counter width helper and default window/threshold values.
package ber_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        COUNT  = 1'b1
    } ber_state_t;

    localparam int BER_WINDOW_DEFAULT     = 511;
    localparam int BER_RESYNC_THR_DEFAULT = 128;

    // Width needed to hold a count of 0..window inclusive.
    function automatic int win_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/ber_delay_line.sv
// Reference delay line: tap L is the reference bit L enabled samples ago,
// tap 0 being the live input. Two independent taps serve search and count.
module ber_delay_line #(
    parameter int NB_LAT = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enbl,
    input  logic              bit_ref,
    input  logic [NB_LAT-1:0] lat_cand,
    input  logic [NB_LAT-1:0] lat_lock,
    output logic              ref_cand,
    output logic              ref_lock
);

    localparam int DEPTH = 2 ** NB_LAT;

    logic [DEPTH-2:0] history;
    logic [DEPTH-1:0] taps;

    assign taps = {history, bit_ref};

    always_ff @(posedge clock) begin
        if (reset) begin
            history <= '0;
        end else if (enbl) begin
            history <= taps[DEPTH-2:0];
        end
    end

    assign ref_cand = taps[lat_cand];
    assign ref_lock = taps[lat_lock];

endmodule

// File: rtl/ber_checker.sv
// Per-branch bit-error-rate checker: searches the reference latency with the
// fewest errors, then counts bits/errors. Optional macro BER_RESYNC_EN re-searches on bad blocks.
module ber_checker
    import ber_pkg::*;
#(
    parameter int NB_LAT     = 9,
    parameter int WINDOW     = BER_WINDOW_DEFAULT,
    parameter int NB_COUNT   = 64,
    parameter int RESYNC_THR = BER_RESYNC_THR_DEFAULT
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enbl,
    input  logic                i_restart,
    input  logic                i_bit_ref,
    input  logic                i_bit_rx,
    output logic                o_sync,
    output logic [NB_LAT-1:0]   o_lat,
    output logic [NB_COUNT-1:0] o_count_bit,
    output logic [NB_COUNT-1:0] o_count_err
);

    localparam int                CW        = win_width(WINDOW);
    localparam logic [CW-1:0]     WIN_LAST  = CW'(WINDOW - 1);
    localparam logic [NB_LAT-1:0] CAND_LAST = '1;

    ber_state_t state, state_next;

    logic [NB_LAT-1:0] cand;
    logic [NB_LAT-1:0] best_lat;
    logic [CW-1:0]     win_cnt;
    logic [CW-1:0]     win_err;
    logic [CW-1:0]     min_err;
    logic [CW-1:0]     win_err_sum;
    logic              ref_cand;
    logic              ref_lock;
    logic              err_cand;
    logic              err_lock;
    logic              win_done;
    logic              search_done;
    logic              better;
    logic              count_en;
    logic              resync_hit;

    ber_delay_line #(
        .NB_LAT(NB_LAT)
    ) u_delay_line (
        .clock   (i_clock),
        .reset   (i_reset),
        .enbl    (i_enbl),
        .bit_ref (i_bit_ref),
        .lat_cand(cand),
        .lat_lock(o_lat),
        .ref_cand(ref_cand),
        .ref_lock(ref_lock)
    );

    assign err_cand    = i_bit_rx ^ ref_cand;
    assign err_lock    = i_bit_rx ^ ref_lock;
    assign win_err_sum = win_err + CW'(err_cand);
    assign win_done    = (state == SEARCH) && i_enbl && (win_cnt == WIN_LAST);
    assign search_done = win_done && (cand == CAND_LAST);
    // Strict less-than keeps the lower latency on a tie.
    assign better      = win_err_sum < min_err;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_restart) begin
            state_next = SEARCH;
        end else begin
            case (state)
                SEARCH:  if (search_done) state_next = COUNT;
                COUNT:   if (resync_hit)  state_next = SEARCH;
                default: state_next = SEARCH;
            endcase
        end
    end

    always_comb begin
        o_sync   = 1'b0;
        count_en = 1'b0;
        if (state == COUNT) begin
            o_sync   = 1'b1;
            count_en = i_enbl;
        end
    end

    // cand wraps to 0 and min_err re-arms after the last window, so a later
    // re-search starts from a clean slate without extra control.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_restart) begin
            cand     <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            min_err  <= '1;
            best_lat <= '0;
        end else if (state == SEARCH && i_enbl) begin
            if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
                cand    <= cand + NB_LAT'(1);
                if (better) begin
                    min_err  <= win_err_sum;
                    best_lat <= cand;
                end
                if (cand == CAND_LAST) begin
                    min_err <= '1;
                end
            end else begin
                win_cnt <= win_cnt + CW'(1);
                win_err <= win_err_sum;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_lat <= '0;
        end else if (!i_restart && search_done) begin
            o_lat <= better ? cand : best_lat;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_restart) begin
            o_count_bit <= '0;
            o_count_err <= '0;
        end else if (count_en) begin
            if (o_count_bit != '1) begin
                o_count_bit <= o_count_bit + NB_COUNT'(1);
            end
            if (err_lock && o_count_err != '1) begin
                o_count_err <= o_count_err + NB_COUNT'(1);
            end
        end
    end

`ifdef BER_RESYNC_EN
    logic [CW-1:0] blk_cnt;
    logic [CW-1:0] blk_err;
    logic [CW-1:0] blk_err_sum;

    assign blk_err_sum = blk_err + CW'(err_lock);
    assign resync_hit  = (state == COUNT) && i_enbl && (blk_cnt == WIN_LAST)
                         && (int'(blk_err_sum) > RESYNC_THR);

    // Blocks are aligned to the moment of lock.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_restart || state != COUNT) begin
            blk_cnt <= '0;
            blk_err <= '0;
        end else if (i_enbl) begin
            if (blk_cnt == WIN_LAST) begin
                blk_cnt <= '0;
                blk_err <= '0;
            end else begin
                blk_cnt <= blk_cnt + CW'(1);
                blk_err <= blk_err_sum;
            end
        end
    end
`else
    logic unused_thr;

    assign resync_hit = 1'b0;
    assign unused_thr = ^RESYNC_THR;
`endif

endmodule

// File: doc/ber_checker.md
# ber_checker

Per-branch bit-error-rate checker feeding the 64-bit bit/error counters that the register file snapshots and reads back over GPIO (opcodes 0x05/0x06). It compares the slicer's hard-decision bit stream against the local transmit PRBS reference. First it searches for the alignment latency with the fewest errors, then locks and accumulates saturating bit and error counts. The design instantiates it twice: I branch and Q branch.

## Interface
Parameters:
- NB_LAT, 9, log2 of reference delay-line depth; candidate latencies 0..2^NB_LAT-1
- WINDOW, 511, enabled samples evaluated per candidate latency
- NB_COUNT, 64, width of bit and error counters
- RESYNC_THR, 128, errors per WINDOW that force re-search (only with BER_RESYNC_EN)

Ports:
- i_clock  in  1  system clock; single clock domain
- i_reset  in  1  synchronous, active-high reset
- i_enbl  in  1  symbol-rate strobe (rate-one enable); all state advances only when high
- i_restart  in  1  clears counters and restarts the search; takes priority over i_enbl
- i_bit_ref  in  1  transmitted PRBS bit for this branch
- i_bit_rx  in  1  received hard decision (slicer MSB) for this branch
- o_sync  out  1  high while in COUNT state
- o_lat  out  NB_LAT  locked latency (best candidate)
- o_count_bit  out  NB_COUNT  bits compared since lock
- o_count_err  out  NB_COUNT  bit errors since lock

## Operation
- Delay line: 2^NB_LAT-bit shift register of i_bit_ref, shifts on i_enbl. ref_d[L] is the reference bit L enabled samples ago; ref_d[0] = current i_bit_ref. Error = i_bit_rx XOR ref_d[L].
- States: SEARCH, COUNT.
- SEARCH: candidate latency cand starts at 0. Each enabled sample increments win_cnt and adds the error to win_err (width clog2(WINDOW+1)). When win_cnt reaches WINDOW-1 with i_enbl high:
  - The final win_err (including the current sample) is compared with min_err using strict less-than. On a tie, the lower latency is kept.
  - If it is lower, min_err and best_lat are updated.
  - win_cnt and win_err clear and cand increments.
  - After cand = 2^NB_LAT-1 completes, o_lat <= best_lat and the state moves to COUNT.
- COUNT: on each enable, o_count_bit += 1 and o_count_err += (i_bit_rx XOR ref_d[o_lat]). Both counters saturate at all-ones independently and never wrap.
- i_restart (any state): counters clear, o_sync clears, state becomes SEARCH, cand/win_cnt/win_err clear, and min_err is set to all-ones. o_lat holds its value until the next lock.
- Reset values: o_sync=0, o_lat=0, o_count_bit=0, o_count_err=0, state SEARCH, cand=0, win_cnt=0, win_err=0, min_err=all-ones, delay line all zeros.
- Reset or restart mid-search discards all partial window results.

## Timing
- Registered outputs; a counter update triggered by an enabled sample is visible one clock later.
- Lock time = 2^NB_LAT × WINDOW enabled samples after reset or restart. o_sync rises on the clock following the last enabled sample of the last window.
- The first counted sample is the first enable after o_sync rises.
- i_restart and i_enbl in the same cycle: restart wins, and that sample is not counted.
- With i_enbl low, all state holds.

## Configuration
- BER_RESYNC_EN defined: in COUNT, a block counter tracks errors over consecutive WINDOW-sample blocks. If a completed block has more than RESYNC_THR errors:
  - the state returns to SEARCH and o_sync drops;
  - o_count_bit and o_count_err hold (they are not cleared), then resume accumulating after relock.
- BER_RESYNC_EN undefined: COUNT exits only on i_reset or i_restart, and RESYNC_THR is unused.

## Structure
- ber_pkg: state enum (SEARCH, COUNT), a clog2-based width helper for win_cnt/win_err, and the default WINDOW and RESYNC_THR constants.
- Sub-module ber_delay_line: the shift register plus a latency-indexed mux, with outputs ref_d[cand] and ref_d[o_lat]. This lets a single delay line serve both states.

## Test plan
- NB_LAT=4, WINDOW=32; i_bit_ref = PRBS9 (seed 0x1AA); i_bit_rx = ref delayed 5 enables; i_enbl every 2nd clock. Required: o_sync=1 after 512 enables, o_lat=5; 1000 enables later o_count_bit=1000, o_count_err=0.
- Same lock, then invert every 100th rx bit. Required after 1000 counted bits: o_count_err=10.
- Assert i_restart together with i_enbl mid-count. Required next cycle: counters=0, o_sync=0; relock after another 512 enables.
- NB_COUNT=8, locked, 300 enables. Required: o_count_bit=255 and it stays at 255.
- i_bit_rx = i_bit_ref (delay 0). Required: o_lat=0 (tie rule keeps the lowest latency).
- Macro set, RESYNC_THR=8: after lock at 5, change the channel delay to 7. Required: o_sync falls after one block, relock with o_lat=7, and counters continue from their held values.
